aes_enc_iter: RTL

- Iterative, parametrised AES encryption engine; successor to the fully unrolled 10-stage AES-128 pipeline.
- Supports AES-128 and AES-256, selectable per block.
- Executes 1 or 2 rounds per clock with on-the-fly key expansion, trading throughput for area.
- Has valid/ready handshakes on both sides and back-pressure on the output; sits between the core-side AES request interface and the result register bank.

---
 rtl/aes_pkg.sv | 65 ++++++
 rtl/aes_round_comb.sv | 39 +++
 rtl/aes_enc_iter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// AES shared definitions: S-box, round constants, byte/word/column helpers,
// state and FSM types, and the round counts for both key sizes.
package aes_pkg;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam int NR_128 = 10;
  localparam int NR_256 = 14;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    rot_word = {w[23:0], w[31:24]};
  endfunction

  // One MixColumns column; byte a0 (row 0) sits in the top byte.
  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    mix_column = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                  a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                  a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                  xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped in
// the final round) and AddRoundKey. Byte i of the state is row i%4, column i/4.
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] next_state
);

  logic [127:0] sb_s;
  logic [127:0] sr_s;
  logic [127:0] mc_s;

  // Round transform; the final round bypasses MixColumns.
  always_comb begin
    sb_s = '0;
    sr_s = '0;
    mc_s = '0;
    for (int i = 0; i < 16; i++) begin
      sb_s[127-8*i -: 8] = SBOX[state[127-8*i -: 8]];
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_s[127-8*(4*c+r) -: 8] = sb_s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc_s[127-32*c -: 32] = mix_column(sr_s[127-32*c -: 32]);
    end
    if (last) begin
      next_state = sr_s ^ round_key;
    end else begin
      next_state = mc_s ^ round_key;
    end
  end

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128/256 encryption engine with on-the-fly key expansion,
// 1 or 2 rounds per clock and valid/ready handshakes on both sides.
module aes_enc_iter
  import aes_pkg::*;
#(
  parameter int SUPPORT_AES256 = 1,
  parameter int ROUNDS_PER_CLK = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_key256,
  input  logic [255:0] in_key,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (ROUNDS_PER_CLK != 1 && ROUNDS_PER_CLK != 2) begin : g_bad_rpc
    $error("aes_enc_iter: ROUNDS_PER_CLK must be 1 or 2");
  end

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;
  localparam logic [3:0] RPC     = 4'(ROUNDS_PER_CLK);
  localparam logic       HAS_256 = (SUPPORT_AES256 != 0);

  // Out-of-range indices only occur on cycles whose key result is discarded.
  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    rcon_of = (idx < 4'd10) ? RCON[idx] : 8'h00;
  endfunction

  // Derive four new key words from the previous four and the trailing word.
  function automatic logic [127:0] expand_half(input logic [127:0] prev,
                                               input logic [31:0]  tw,
                                               input logic         rot,
                                               input logic [7:0]   rc);
    logic [31:0] t, w0, w1, w2, w3;
    if (rot) begin
      t = sub_word(rot_word(tw)) ^ {rc, 24'h000000};
    end else begin
      t = sub_word(tw);
    end
    w0 = prev[127:96] ^ t;
    w1 = prev[95:64] ^ w0;
    w2 = prev[63:32] ^ w1;
    w3 = prev[31:0] ^ w2;
    expand_half = {w0, w1, w2, w3};
  endfunction

  // Returns {round key for round rnd, key window for round rnd+1}.
  // AES-128: window[255:128] is the previous round key; the new key replaces it.
  // AES-256: window holds {rk[rnd-1], rk[rnd]}; it slides by one round key,
  // and odd rounds produce an even-indexed key (RotWord + Rcon step).
  function automatic logic [383:0] key_step(input logic         mode,
                                            input logic [3:0]   rnd,
                                            input logic [255:0] win);
    logic [127:0] nxt;
    if (mode) begin
      nxt = expand_half(win[255:128], win[31:0], rnd[0], rcon_of({1'b0, rnd[3:1]}));
      key_step = {win[127:0], win[127:0], nxt};
    end else begin
      nxt = expand_half(win[255:128], win[159:128], 1'b1, rcon_of(rnd - 4'd1));
      key_step = {nxt, nxt, win[127:0]};
    end
  endfunction

  logic [1:0]   state_r, state_nx_s;
  logic [127:0] st_r;
  logic [255:0] key_r;
  logic         mode_r;
  logic [3:0]   round_cnt_r;
  logic         in_ready_r, out_valid_r, busy_r;
  logic [127:0] out_data_r;

  logic [3:0]   nr_s, rnd_last_s;
  logic [127:0] rk_a_s, st_a_s, st_fin_s;
  logic [255:0] win_a_s, win_fin_s;
  logic         last_a_s, accept_s, done_s;

  assign nr_s       = mode_r ? 4'(NR_256) : 4'(NR_128);
  assign rnd_last_s = round_cnt_r + RPC - 4'd1;
  assign done_s     = (rnd_last_s == nr_s);
  assign accept_s   = in_valid && in_ready_r && (state_r == ST_IDLE);

  assign {rk_a_s, win_a_s} = key_step(mode_r, round_cnt_r, key_r);
  assign last_a_s          = (round_cnt_r == nr_s);

  aes_round_comb u_round_a (
    .state      (st_r),
    .round_key  (rk_a_s),
    .last       (last_a_s),
    .next_state (st_a_s)
  );

  if (ROUNDS_PER_CLK == 2) begin : g_two
    logic [3:0]   rnd_b_s;
    logic [127:0] rk_b_s;
    logic [255:0] win_b_s;
    logic         last_b_s;

    assign rnd_b_s           = round_cnt_r + 4'd1;
    assign {rk_b_s, win_b_s} = key_step(mode_r, rnd_b_s, win_a_s);
    assign last_b_s          = (rnd_b_s == nr_s);
    assign win_fin_s         = win_b_s;

    aes_round_comb u_round_b (
      .state      (st_a_s),
      .round_key  (rk_b_s),
      .last       (last_b_s),
      .next_state (st_fin_s)
    );
  end else begin : g_one
    assign st_fin_s  = st_a_s;
    assign win_fin_s = win_a_s;
  end

  // Next-state logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nx_s = ST_RUN;
        else          state_nx_s = ST_IDLE;
      end
      ST_RUN: begin
        if (done_s) state_nx_s = ST_DONE;
        else        state_nx_s = ST_RUN;
      end
      ST_DONE: begin
        if (out_ready) state_nx_s = ST_IDLE;
        else           state_nx_s = ST_DONE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      st_r        <= 128'h0;
      key_r       <= 256'h0;
      mode_r      <= 1'b0;
      round_cnt_r <= 4'd0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      out_data_r  <= 128'h0;
    end else begin
      state_r    <= state_nx_s;
      in_ready_r <= (state_nx_s == ST_IDLE);
      busy_r     <= (state_nx_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            st_r        <= in_data ^ in_key[255:128];
            key_r       <= HAS_256 ? in_key : {in_key[255:128], 128'h0};
            mode_r      <= in_key256 & HAS_256;
            round_cnt_r <= 4'd1;
          end
        end
        ST_RUN: begin
          st_r        <= st_fin_s;
          key_r       <= win_fin_s;
          round_cnt_r <= round_cnt_r + RPC;
          if (done_s) begin
            out_data_r  <= st_fin_s;
            out_valid_r <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) out_valid_r <= 1'b0;
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;

endmodule
